// File: rtl/cpuif_master_pkg.sv
// Register-access bus types shared by cpuif initiators and the register map,
// plus the command/response records and FSM state of cpuif_master.
package pkg_cpu_if;
  localparam int CPUIF_ADDR_W = 12;
  localparam int CPUIF_DATA_W = 32;

  typedef struct packed {
    logic                    req;
    logic                    req_is_wr;
    logic [CPUIF_ADDR_W-1:0] addr;
    logic [CPUIF_DATA_W-1:0] wr_data;
    logic [CPUIF_DATA_W-1:0] wr_biten;
  } cpu_if_o;

  typedef struct packed {
    logic                    req_stall_wr;
    logic                    req_stall_rd;
    logic                    rd_ack;
    logic                    rd_err;
    logic [CPUIF_DATA_W-1:0] rd_data;
    logic                    wr_ack;
    logic                    wr_err;
  } cpu_if_i;

  typedef struct packed {
    logic                    is_wr;
    logic [CPUIF_ADDR_W-1:0] addr;
    logic [CPUIF_DATA_W-1:0] wr_data;
    logic [CPUIF_DATA_W-1:0] wr_biten;
  } cpuif_cmd_t;

  typedef struct packed {
    logic                    is_wr;
    logic [CPUIF_DATA_W-1:0] rd_data;
    logic                    err;
  } cpuif_rsp_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} cpuif_master_state_e;
endpackage

// File: rtl/cpuif_master_if.sv
// Host-side command/response valid-ready streams of cpuif_master.
// master = command source, slave = cpuif_master.
interface cpuif_master_if;
  import pkg_cpu_if::*;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_is_wr;
  logic [CPUIF_ADDR_W-1:0] cmd_addr;
  logic [CPUIF_DATA_W-1:0] cmd_wr_data;
  logic [CPUIF_DATA_W-1:0] cmd_wr_biten;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_is_wr;
  logic [CPUIF_DATA_W-1:0] rsp_rd_data;
  logic                    rsp_err;

  modport master (output cmd_valid, cmd_is_wr, cmd_addr, cmd_wr_data, cmd_wr_biten, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_is_wr, rsp_rd_data, rsp_err);
  modport slave  (input  cmd_valid, cmd_is_wr, cmd_addr, cmd_wr_data, cmd_wr_biten, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_is_wr, rsp_rd_data, rsp_err);
endinterface

// File: rtl/cpuif_master.sv
// Single-outstanding cpuif initiator: command stream in, cpuif transaction, response stream out.
// Optional request-to-ack watchdog enabled by CPUIF_MASTER_TIMEOUT_EN.
module cpuif_master
  import pkg_cpu_if::*;
#(
  parameter int ADDR_W         = CPUIF_ADDR_W,
  parameter int DATA_W         = CPUIF_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  cpuif_master_if.slave  bus,
  output cpu_if_o        cpuif_o,
  input  cpu_if_i        cpuif_i
);
  // Widths are carried by the shared bus types; reject a mismatched build.
  if (ADDR_W != CPUIF_ADDR_W || DATA_W != CPUIF_DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cpuif_master: parameters disagree with pkg_cpu_if");
  end

  cpuif_master_state_e state;
  cpuif_rsp_t          rsp_q;
  logic                cmd_ready_r;
  logic                rsp_valid_r;

  logic              is_wr, stall, ack, err, expire;
  logic [DATA_W-1:0] ack_data;

  assign is_wr    = cpuif_o.req_is_wr;
  assign stall    = is_wr ? cpuif_i.req_stall_wr : cpuif_i.req_stall_rd;
  assign ack      = is_wr ? cpuif_i.wr_ack : cpuif_i.rd_ack;
  assign err      = is_wr ? cpuif_i.wr_err : cpuif_i.rd_err;
  assign ack_data = is_wr ? '0 : cpuif_i.rd_data;

`ifdef CPUIF_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  // Counter is 0 in the first ISSUE cycle, so expiry lands on the TIMEOUT_CYCLES-th cycle.
  assign expire = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cpuif_o     <= '0;
      rsp_q       <= '0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
`ifdef CPUIF_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
`ifdef CPUIF_MASTER_TIMEOUT_EN
      if (state == ISSUE || state == WAIT_ACK) tmo_cnt <= tmo_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (cmd_ready_r && bus.cmd_valid) begin
            cmd_ready_r <= 1'b0;
            cpuif_o     <= '{req: 1'b1, req_is_wr: bus.cmd_is_wr, addr: bus.cmd_addr,
                             wr_data: bus.cmd_wr_data, wr_biten: bus.cmd_wr_biten};
            state       <= ISSUE;
`ifdef CPUIF_MASTER_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ISSUE: begin
          // An ack coincident with acceptance skips WAIT_ACK.
          if (!stall && ack) begin
            cpuif_o.req <= 1'b0;
            rsp_q       <= '{is_wr: is_wr, rd_data: ack_data, err: err};
            rsp_valid_r <= 1'b1;
            state       <= RESP;
          end else if (expire) begin
            cpuif_o.req <= 1'b0;
            rsp_q       <= '{is_wr: is_wr, rd_data: '0, err: 1'b1};
            rsp_valid_r <= 1'b1;
            state       <= RESP;
          end else if (!stall) begin
            cpuif_o.req <= 1'b0;
            state       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            rsp_q       <= '{is_wr: is_wr, rd_data: ack_data, err: err};
            rsp_valid_r <= 1'b1;
            state       <= RESP;
          end else if (expire) begin
            rsp_q       <= '{is_wr: is_wr, rd_data: '0, err: 1'b1};
            rsp_valid_r <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_is_wr   = rsp_q.is_wr;
  assign bus.rsp_rd_data = rsp_q.rd_data;
  assign bus.rsp_err     = rsp_q.err;
endmodule

// File: doc/cpuif_master.md
Name: cpuif_master

Overview:
- Initiator for the pkg_cpu_if register-access interface. It drives the request side (`cpu_if_o`) and consumes the response side (`cpu_if_i`).
- It converts a valid/ready command stream into single-outstanding cpuif transactions and returns each result on a valid/ready response stream.
- It sits between a host-facing command source (e.g. SPI/UART command decoder) and the cloud_ceiling register map.

Parameters:
- ADDR_W, 12, command/cpuif address width; must equal the width of the pkg_cpu_if addr field.
- DATA_W, 32, data/biten width; must equal the width of the pkg_cpu_if wr_data/rd_data fields.
- TIMEOUT_CYCLES, 1024, maximum cycles from request issue to ack; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when valid&&ready.
- cmd_is_wr  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_W  byte address.
- cmd_wr_data  input  DATA_W  write data.
- cmd_wr_biten  input  DATA_W  write bit enables.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when valid&&ready.
- rsp_is_wr  output  1  echo of the command type.
- rsp_rd_data  output  DATA_W  read data (0 for writes).
- rsp_err  output  1  rd_err/wr_err from the regmap, or timeout.
- cpuif_o  output  pkg_cpu_if::cpu_if_o  req, req_is_wr, addr, wr_data, wr_biten.
- cpuif_i  input  pkg_cpu_if::cpu_if_i  req_stall_wr, req_stall_rd, rd_ack, rd_err, rd_data, wr_ack, wr_err.

Behaviour:
- Reset: asynchronous, active-high, as already decided.
  - While reset is asserted, all outputs are 0 and the FSM is IDLE.
  - A transaction in flight when reset asserts is discarded; no response is produced.
- FSM states: IDLE, ISSUE, WAIT_ACK, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch all cmd fields into registers and go to ISSUE on the next cycle.
  - cmd_ready=0 in every other state, so only one transaction is outstanding.
- ISSUE:
  - cpuif_o.req=1 with the latched fields.
  - Relevant stall: req_stall_wr for writes, req_stall_rd for reads.
  - If the relevant stall is 1, hold req and all fields stable and remain in ISSUE.
  - If the stall is 0, the request is accepted this cycle and the next state is WAIT_ACK.
  - Exception: if the matching ack is already high in the accepting cycle, go straight to RESP.
- WAIT_ACK:
  - req=0.
  - Matching ack: rd_ack for reads, wr_ack for writes.
  - On the matching ack, capture rd_data (reads only; writes capture 0) and the matching err, then go to RESP.
  - A non-matching ack is ignored.
- RESP:
  - rsp_valid=1 with the captured fields, held stable until rsp_ready; then go to IDLE.
  - rsp_valid is registered; it is never combinationally driven from cpuif_i.
- Acks arriving in IDLE or RESP are ignored.
- Latency with no stall, ack one cycle after req, and rsp_ready held high:
  - cmd accept at cycle 0, req at cycle 1, ack at cycle 2, rsp_valid at cycle 3.
  - Next cmd_ready at cycle 4.
- cpuif_o.addr, wr_data, wr_biten and req_is_wr hold their latched values outside ISSUE; only req pulses.
- Back-to-back: a new command cannot be accepted in the same cycle as rsp handshake completion; throughput is ≥4 cycles/transaction.

Optional Feature:
- Macro: CPUIF_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ISSUE and increments every cycle in ISSUE or WAIT_ACK.
  - On reaching TIMEOUT_CYCLES with no matching ack: drop req, go to RESP with rsp_err=1 and rsp_rd_data=0.
  - An ack in the same cycle as expiry wins; the result is a normal response.
  - A late ack from a timed-out transaction that arrives in IDLE, RESP or before the next request is ignored.
  - A late ack arriving while the next command is in WAIT_ACK is indistinguishable from a real ack and is not detected.
- Undefined: no counter; the FSM waits indefinitely in ISSUE/WAIT_ACK.

Decomposition:
- pkg_cpu_if (existing) supplies cpu_if_o/cpu_if_i and the address/data width constants.
- Add to pkg_cpu_if:
  - typedef cpuif_cmd_t {is_wr, addr, wr_data, wr_biten}.
  - typedef cpuif_rsp_t {is_wr, rd_data, err}.
  - FSM state enum cpuif_master_state_e.
- No sub-module; the timeout counter stays inline.

Test Plan:
- Read, no stall: cmd read addr 0x010; regmap rd_ack one cycle after req with rd_data 0xA5A5_0001 → exactly one req cycle with req_is_wr=0, addr 0x010; response rsp_rd_data=0xA5A5_0001, rsp_err=0, rsp_is_wr=0 at cycle 3.
- Write with stall: cmd write addr 0x004, data 0x0000_00FF, biten 0xFFFF_FFFF; req_stall_wr=1 for 3 cycles → req held 4 cycles with stable fields; wr_ack → response rsp_is_wr=1, rsp_err=0, rsp_rd_data=0.
- Error plus backpressure: read with rd_err=1, rsp_ready=0 for 5 cycles → rsp_valid and rsp_err=1 stable 5 cycles; cmd_ready=0 throughout; one response only.
- Mismatched and stray acks: wr_ack during a pending read is ignored; rd_ack pulse in IDLE causes no response.
- Reset mid-transaction: assert reset in WAIT_ACK → all outputs 0 asynchronously; after release, cmd_ready=1 and no response is emitted for the aborted transaction.
- Timeout (CPUIF_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16): read with no ack → rsp_err=1, rsp_rd_data=0 after 16 cycles; an ack arriving on the expiry cycle yields a normal response.
